// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/PC stage: state encoding, branch-op codes,
// opcode constants, IR field positions and the branch-condition helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam logic [2:0] BROP_BR   = 3'b000;
  localparam logic [2:0] BROP_BMI  = 3'b001;
  localparam logic [2:0] BROP_BPL  = 3'b010;
  localparam logic [2:0] BROP_BZ   = 3'b011;
  localparam logic [2:0] BROP_NONE = 3'b100;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BR   = 6'h10;
  localparam logic [5:0] OP_BMI  = 6'h11;
  localparam logic [5:0] OP_BPL  = 6'h12;
  localparam logic [5:0] OP_BZ   = 6'h13;
  localparam logic [5:0] OP_HALT = 6'h3f;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int FUNC_MSB = 4;
  localparam int IMM_MSB  = 15;
  localparam int OFF_W    = 21;

  // BPL means strictly positive as a signed value; codes above BZ never branch.
  function automatic logic br_taken(input logic [2:0] br_op, input logic [31:0] rs_val);
    logic taken;
    taken = 1'b0;
    case (br_op)
      BROP_BR:  taken = 1'b1;
      BROP_BMI: taken = rs_val[31];
      BROP_BPL: taken = !rs_val[31] && (rs_val != 32'd0);
      BROP_BZ:  taken = (rs_val == 32'd0);
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// Next-PC computation: pc+1, plus the sign-extended 21-bit offset when taken.
module fetch_unit_branch_resolve
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        br_op,
  input  logic [31:0]       rs_val,
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] pc_inc;

  always_comb begin
    off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
    pc_inc  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    next_pc = br_taken(br_op, rs_val) ? (pc_inc + off_ext) : pc_inc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: req/ack fetch into the IR, decode of IR fields,
// and PC advance on each rising edge of the control unit's upd_pc.
//
//   state     | meaning
//   ST_IDLE   | in or just out of reset, no request
//   ST_FETCH  | imem_req high at pc, waiting for imem_ack
//   ST_HOLD   | IR valid, waiting for an upd_pc rising edge
//   ST_UPDATE | pc advanced (branch resolved), then refetch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_pc,
  input  logic [2:0]        br_op,
  input  logic [31:0]       rs_val,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        func,
  output logic [31:0]       imm,
  output logic              instr_valid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              upd_q, upd_d;
  logic [ADDR_W-1:0] next_pc;
  logic              upd_rise;

  fetch_unit_branch_resolve #(.ADDR_W(ADDR_W)) u_branch_resolve (
    .br_op   (br_op),
    .rs_val  (rs_val),
    .pc      (pc_q),
    .offset  (ir_q[OFF_W-1:0]),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  // The edge register samples upd_pc every cycle so a level that is already
  // high when HOLD is entered cannot look like a fresh edge.
  assign upd_rise = upd_pc && !upd_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    upd_d   = upd_pc;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (upd_rise) begin
          valid_d = 1'b0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_d    = next_pc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    imem_addr   = pc_q;
    pc          = pc_q;
    instr_valid = valid_q;
    opcode      = ir_q[OPC_MSB:OPC_LSB];
    rs          = ir_q[RS_MSB:RS_LSB];
    rt          = ir_q[RT_MSB:RT_LSB];
    rd          = ir_q[RD_MSB:RD_LSB];
    func        = ir_q[FUNC_MSB:0];
    imm         = {{16{ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: branch table plus hand sequences for the
// handshake, edge detection, reset and wrap corner cases.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_pc;
  logic [2:0]  br_op;
  logic [31:0] rs_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, func;
  logic [31:0] imm;
  logic        instr_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .upd_pc(upd_pc), .br_op(br_op), .rs_val(rs_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .func(func), .imm(imm), .instr_valid(instr_valid)
  );

  typedef struct {
    string       name;
    logic [2:0]  br;
    logic [31:0] rsv;
    logic [20:0] off;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] cur;
  logic [31:0] nxt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    check({nm, "_req_timeout"}, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input string nm, input logic [31:0] ir);
    wait_req(nm);
    imem_rdata = ir;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    check({nm, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire(input string nm, input logic [2:0] br, input logic [31:0] rsv,
                        output logic [31:0] addr);
    br_op  = br;
    rs_val = rsv;
    upd_pc = 1'b1;
    tick();
    upd_pc = 1'b0;
    check({nm, "_retired"}, {31'd0, instr_valid}, 32'd0);
    tick();
    check({nm, "_lat_req"}, {31'd0, imem_req}, 32'd1);
    addr = imem_addr;
  endtask

  task automatic run_instr(input string nm, input logic [20:0] off, input logic [2:0] br,
                           input logic [31:0] rsv, output logic [31:0] addr);
    fetch(nm, {OP_BR, 5'd3, off});
    retire(nm, br, rsv, addr);
  endtask

  initial begin
    vecs[0]  = '{"none",      BROP_NONE, 32'd0,         21'd0,        32'd11};
    vecs[1]  = '{"bz_taken",  BROP_BZ,   32'd0,         -21'sd4,      32'd7};
    vecs[2]  = '{"bz_not",    BROP_BZ,   32'd1,         -21'sd4,      32'd11};
    vecs[3]  = '{"bmi_taken", BROP_BMI,  32'h8000_0000, 21'd5,        32'd16};
    vecs[4]  = '{"bmi_not",   BROP_BMI,  32'h7fff_ffff, 21'd5,        32'd11};
    vecs[5]  = '{"bpl_zero",  BROP_BPL,  32'd0,         21'd5,        32'd11};
    vecs[6]  = '{"bpl_one",   BROP_BPL,  32'd1,         21'd5,        32'd16};
    vecs[7]  = '{"bpl_neg",   BROP_BPL,  32'hffff_ffff, 21'd5,        32'd11};
    vecs[8]  = '{"br_back",   BROP_BR,   32'd0,         -21'sd4,      32'd7};
    vecs[9]  = '{"op101",     3'b101,    32'd0,         21'd5,        32'd11};
    vecs[10] = '{"op111",     3'b111,    32'd0,         21'd5,        32'd11};
    vecs[11] = '{"br_minoff", BROP_BR,   32'd0,         21'h10_0000,  32'hfff0_000b};
    vecs[12] = '{"br_maxoff", BROP_BR,   32'd5,         21'h0f_ffff,  32'h0010_000a};

    rst_n = 1'b0; upd_pc = 1'b0; br_op = BROP_NONE; rs_val = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    tick(); tick(); tick();
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc",    pc,                   32'd0);
    check("rst_ir",    {26'd0, opcode},      32'd0);

    // Reset release, ack arriving after three wait cycles.
    rst_n = 1'b1;
    tick();
    check("t1_req",  {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr,         32'd0);
    tick(); tick(); tick();
    check("t1_wait_req",   {31'd0, imem_req},    32'd1);
    check("t1_wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h0400_0005;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    check("t1_valid",  {31'd0, instr_valid}, 32'd1);
    check("t1_opcode", {26'd0, opcode},      32'd1);
    check("t1_rs",     {27'd0, rs},          32'd0);
    check("t1_imm",    imm,                  32'd5);
    check("t1_hold_req", {31'd0, imem_req},  32'd0);
    retire("t1", BROP_NONE, 32'd0, nxt);
    check("t1_next", nxt, 32'd1);
    cur = 32'd1;

    // Branch table, each vector starts from pc=10 reached by an unconditional branch.
    foreach (vecs[i]) begin
      logic [31:0] d;
      d = 32'd10 - cur - 32'd1;
      run_instr({vecs[i].name, "_setup"}, d[20:0], BROP_BR, 32'd0, nxt);
      check({vecs[i].name, "_setup_pc"}, nxt, 32'd10);
      run_instr(vecs[i].name, vecs[i].off, vecs[i].br, vecs[i].rsv, nxt);
      check(vecs[i].name, nxt, vecs[i].exp);
      cur = vecs[i].exp;
    end

    // upd_pc held high for five cycles advances the PC once.
    fetch("hold", {OP_ADDI, 26'd0});
    br_op  = BROP_NONE;
    upd_pc = 1'b1;
    tick(); tick();
    check("hold_req",  {31'd0, imem_req}, 32'd1);
    check("hold_addr", imem_addr,         cur + 32'd1);
    imem_rdata = {OP_ADDI, 26'd7};
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    tick(); tick();
    upd_pc = 1'b0;
    tick(); tick();
    check("hold_no_retrig_req",   {31'd0, imem_req},    32'd0);
    check("hold_no_retrig_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_pc",              pc,                   cur + 32'd1);

    // Reset in the middle of a fetch, with an ack that arrives too late.
    upd_pc = 1'b1;
    tick();
    upd_pc = 1'b0;
    tick();
    check("rstmid_in_fetch", {31'd0, imem_req}, 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hdead_beef;
    tick();
    check("rstmid_pc",    pc,                   32'd0);
    check("rstmid_valid", {31'd0, instr_valid}, 32'd0);
    check("rstmid_req",   {31'd0, imem_req},    32'd0);
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("rstmid_refetch_req",  {31'd0, imem_req},    32'd1);
    check("rstmid_refetch_addr", imem_addr,            32'd0);
    check("rstmid_late_ack",     {31'd0, instr_valid}, 32'd0);
    check("rstmid_ir",           {26'd0, opcode},      32'd0);

    // Wrap at the top of the address space.
    run_instr("wrap_setup", -21'sd2, BROP_BR, 32'd0, nxt);
    check("wrap_top", nxt, 32'hffff_ffff);
    run_instr("wrap", 21'd0, BROP_NONE, 32'd0, nxt);
    check("wrap_zero", nxt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
